// File: rtl/spi_flash_reader_pkg.sv
// Shared SPI flash opcodes, command encoding and reader FSM states.
// Pure definitions: no timing and no flow control of its own.
package spi_flash_reader_pkg;

  localparam logic [7:0] OPC_RESUME    = 8'hAB;
  localparam logic [7:0] OPC_READ_ID   = 8'h90;
  localparam logic [7:0] OPC_READ      = 8'h03;
  localparam logic [7:0] OPC_FAST_READ = 8'h0B;

  typedef enum logic [1:0] {
    OP_RESUME    = 2'b00,
    OP_READ_ID   = 2'b01,
    OP_READ      = 2'b10,
    OP_FAST_READ = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD,
    ST_GAP,
    ST_WAIT
  } state_e;

  function automatic logic [7:0] op_to_opcode(input cmd_op_e op);
    logic [7:0] opc;
    case (op)
      OP_RESUME:  opc = OPC_RESUME;
      OP_READ_ID: opc = OPC_READ_ID;
      OP_READ:    opc = OPC_READ;
      default:    opc = OPC_FAST_READ;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/spi_flash_reader_shift.sv
// SPI mode-0 byte engine: one byte takes 16*CLK_DIV clk cycles, MSB first.
// No backpressure; a start pulse in the byte_done cycle chains the next byte seamlessly.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             active;
  logic             sck_q;
  logic             half_end;

  assign half_end  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign byte_done = half_end && sck_q && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      active  <= 1'b0;
      sck_q   <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      tx_sh   <= tx_byte;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sck_q) begin
          // Rising edge: the flash has had a full low half-period to settle miso.
          sck_q <= 1'b1;
          rx_sh <= {rx_sh[6:0], miso};
        end else begin
          sck_q <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign sck     = sck_q;
  assign mosi    = active & tx_sh[7];
  assign busy    = active;
  assign rx_byte = rx_sh;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI NOR read sequencer (RESUME/READ_ID/READ, FAST_READ with SPI_FLASH_FAST_READ_EN); cs falls the cycle after accept.
// Backpressure: a byte finishing while rd_valid is still pending parks the bus in HOLD (sck low, cs low).
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int LEN_W    = 12,
  parameter int CS_GAP   = 4,
  parameter int RES_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cs,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int CNT_MAX = (CS_GAP > RES_WAIT) ? CS_GAP : RES_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  cmd_op_e          op_q, op_d, op_in;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_q;
  logic             accept;
  logic             go;

  logic             eng_start;
  logic [7:0]       eng_tx;
  logic             eng_busy;
  logic             eng_done;
  logic [7:0]       eng_rx;

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (eng_start),
    .tx_byte   (eng_tx),
    .miso      (miso),
    .sck       (sck),
    .mosi      (mosi),
    .busy      (eng_busy),
    .byte_done (eng_done),
    .rx_byte   (eng_rx)
  );

  assign op_in     = cmd_op_e'(cmd_op);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = rdy_q && !busy;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !rd_ready;
    done_d     = 1'b0;
    err_d      = 1'b0;
    eng_start  = 1'b0;
    eng_tx     = 8'h00;
    go         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op_in;
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          case (op_in)
            OP_RESUME: go = 1'b1;
            OP_READ_ID: begin
              go     = 1'b1;
              addr_d = 24'h000000;
              rem_d  = LEN_W'(2);
            end
            OP_READ: begin
              if (cmd_len == '0) done_d = 1'b1;
              else               go     = 1'b1;
            end
            default: begin
`ifdef SPI_FLASH_FAST_READ_EN
              if (cmd_len == '0) done_d = 1'b1;
              else               go     = 1'b1;
`else
              done_d = 1'b1;
              err_d  = 1'b1;
`endif
            end
          endcase
          if (go) begin
            state_d   = ST_OPCODE;
            cs_d      = 1'b0;
            eng_start = 1'b1;
            eng_tx    = op_to_opcode(op_in);
          end
        end
      end

      ST_OPCODE: begin
        if (eng_done) begin
          if (op_q == OP_RESUME) begin
            state_d = ST_GAP;
            cs_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d   = ST_ADDR;
            eng_start = 1'b1;
            eng_tx    = addr_q[23:16];
            addr_d    = {addr_q[15:0], 8'h00};
            idx_d     = 2'd0;
          end
        end
      end

      // addr_q is consumed top byte first by shifting left.
      ST_ADDR: begin
        if (eng_done) begin
          eng_start = 1'b1;
          if (idx_q != 2'd2) begin
            eng_tx = addr_q[23:16];
            addr_d = {addr_q[15:0], 8'h00};
            idx_d  = idx_q + 2'd1;
          end else begin
`ifdef SPI_FLASH_FAST_READ_EN
            state_d = (op_q == OP_FAST_READ) ? ST_DUMMY : ST_DATA;
`else
            state_d = ST_DATA;
`endif
          end
        end
      end

`ifdef SPI_FLASH_FAST_READ_EN
      ST_DUMMY: begin
        if (eng_done) begin
          eng_start = 1'b1;
          state_d   = ST_DATA;
        end
      end
`endif

      ST_DATA: begin
        if (eng_done) begin
          if (!rd_valid_q || rd_ready) begin
            rd_data_d  = eng_rx;
            rd_valid_d = 1'b1;
            rem_d      = rem_q - LEN_W'(1);
            eng_start  = (rem_q != LEN_W'(1));
          end else begin
            // Finished byte stays in the engine's rx register until the slot frees.
            state_d = ST_HOLD;
          end
        end else if (!eng_busy && rem_q == '0 && (!rd_valid_q || rd_ready)) begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (rd_ready) begin
          rd_data_d  = eng_rx;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - LEN_W'(1);
          eng_start  = (rem_q != LEN_W'(1));
          state_d    = ST_DATA;
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          cnt_d = '0;
          if (op_q == OP_RESUME) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(RES_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RESUME;
      addr_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      cs_q       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
    end
  end

  assign cs       = cs_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboarded bench for spi_flash_reader with a behavioural mode-0 flash model.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [23:0] cmd_addr = 24'h0;
  logic [11:0] cmd_len = 12'h0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy, done, err, cs, sck, mosi;
  logic        miso = 1'b0;

  spi_flash_reader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: decodes opcode/address from mosi, answers on miso after falling sck.
  logic        cs_p = 1'b1, sck_p = 1'b0;
  int          nbit = 0, cs_low_cnt = 0, n_cs_fall = 0, n_sck_rise = 0;
  int          last_cs_low = 0, last_nbit = 0, rise_cyc = 0;
  logic [31:0] hdr = 32'h0, last_hdr = 32'h0;
  logic [7:0]  dum = 8'h0, last_dum = 8'h0;

  function automatic logic flash_bit(input logic [31:0] h, input int n);
    int d, k;
    logic [7:0]  b;
    logic [23:0] a;
    d = (h[31:24] == 8'h0B) ? 40 : 32;
    if (n < d) return 1'b0;
    k = (n - d) / 8;
    a = h[23:0] + 24'(k);
    if (h[31:24] == 8'h90) b = (k % 2 == 0) ? 8'hEF : 8'h13;
    else                   b = a[7:0] + 8'h11;
    return b[7 - ((n - d) % 8)];
  endfunction

  always @(negedge clk) begin
    if (cs_p && !cs) begin
      nbit = 0; hdr = 32'h0; dum = 8'h0; cs_low_cnt = 0; n_cs_fall++;
    end
    if (!cs) begin
      cs_low_cnt++;
      if (!sck_p && sck) begin
        n_sck_rise++;
        if (nbit < 32)      hdr = {hdr[30:0], mosi};
        else if (nbit < 40) dum = {dum[6:0], mosi};
        nbit++;
      end
      if (sck_p && !sck) miso = flash_bit(hdr, nbit);
    end
    if (!cs_p && cs) begin
      last_cs_low = cs_low_cnt; last_nbit = nbit; last_hdr = hdr; last_dum = dum; rise_cyc = cyc;
    end
    cs_p = cs;
    sck_p = sck;
  end

  int          n_checks = 0, n_fail = 0;
  logic [7:0]  exp_rd[$];
  logic        exp_err[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no/unexpected event, expected DUT response", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) fail_now("rd_unexpected");
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_err.size() == 0) fail_now("done_unexpected");
        else check("err", err, exp_err.pop_front());
      end
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [23:0] a, input logic [11:0] l,
                          output int acc_cyc);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    int t = 0;
    dcyc = -1;
    while (t < bound) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
      t++;
    end
    if (dcyc < 0) fail_now("done_timeout");
  endtask

  initial begin
    int acc, dc, fall0, r0, t;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1); check("rst_sck", sck, 0); check("rst_mosi", mosi, 0);
    check("rst_rd_valid", rd_valid, 0); check("rst_done", done, 0); check("rst_err", err, 0);
    check("rst_busy", busy, 0); check("rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1; #1;
    check("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("cmd_ready_first_edge", cmd_ready, 1);

    // RESUME
    exp_err.push_back(1'b0);
    send_cmd(2'b00, 24'h0, 12'h0, acc);
    check("busy_after_accept", busy, 1);
    check("ready_while_busy", cmd_ready, 0);
    wait_done(500, dc);
    check("resume_opcode", last_hdr[7:0], 8'hAB);
    check("resume_bits", last_nbit, 8);
    check("resume_cs_low", last_cs_low, 32);
    check("resume_done_delay", dc - rise_cyc, 68);

    // READ_ID
    exp_rd.push_back(8'hEF); exp_rd.push_back(8'h13); exp_err.push_back(1'b0);
    send_cmd(2'b01, 24'hFFFFFF, 12'h0, acc);
    wait_done(1000, dc);
    check("rdid_hdr", last_hdr, 32'h90000000);
    check("rdid_bits", last_nbit, 48);

    // READ with backpressure
    @(posedge clk); #1; rd_ready = 1'b0;
    exp_rd.push_back(8'h56); exp_rd.push_back(8'h57);
    exp_rd.push_back(8'h58); exp_rd.push_back(8'h59);
    exp_err.push_back(1'b0);
    send_cmd(2'b10, 24'h012345, 12'd4, acc);
    t = 0;
    while (!rd_valid && t < 1000) begin @(negedge clk); t++; end
    if (!rd_valid) fail_now("first_byte_timeout");
    repeat (50) @(negedge clk);
    r0 = n_sck_rise;
    repeat (50) @(negedge clk);
    check("hold_sck_edges", n_sck_rise - r0, 0);
    check("hold_cs_low", cs, 0);
    check("hold_sck_low", sck, 0);
    @(posedge clk); #1; rd_ready = 1'b1;
    wait_done(1000, dc);
    check("read_hdr", last_hdr, 32'h03012345);
    check("read_bits", last_nbit, 64);
    check("read_all_bytes", exp_rd.size(), 0);

    // READ len 0
    exp_err.push_back(1'b0);
    fall0 = n_cs_fall;
    send_cmd(2'b10, 24'h000010, 12'd0, acc);
    wait_done(20, dc);
    check("len0_latency", dc - acc + 1, 1);
    check("len0_no_cs", n_cs_fall - fall0, 0);

`ifdef SPI_FLASH_FAST_READ_EN
    exp_rd.push_back(8'hDE); exp_rd.push_back(8'hDF); exp_err.push_back(1'b0);
    send_cmd(2'b11, 24'h00ABCD, 12'd2, acc);
    wait_done(1000, dc);
    check("fast_hdr", last_hdr, 32'h0B00ABCD);
    check("fast_dummy_mosi", last_dum, 8'h00);
    check("fast_bits", last_nbit, 56);
`else
    exp_err.push_back(1'b1);
    fall0 = n_cs_fall;
    send_cmd(2'b11, 24'h00ABCD, 12'd2, acc);
    wait_done(20, dc);
    check("illegal_latency", dc - acc + 1, 1);
    check("illegal_no_cs", n_cs_fall - fall0, 0);
`endif

    // Reset mid-DATA
    for (int i = 0; i < 8; i++) exp_rd.push_back(8'h11 + 8'(i));
    exp_err.push_back(1'b0);
    send_cmd(2'b10, 24'h000100, 12'd8, acc);
    t = 0;
    while (exp_rd.size() > 6 && t < 2000) begin @(negedge clk); t++; end
    if (exp_rd.size() > 6) fail_now("mid_data_timeout");
    repeat (5) @(negedge clk);
    check("mid_cs_active", cs, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_rd.delete(); exp_err.delete();
    #1;
    check("async_cs", cs, 1); check("async_sck", sck, 0); check("async_rd_valid", rd_valid, 0);
    check("async_busy", busy, 0); check("async_mosi", mosi, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rd.push_back(8'hEF); exp_rd.push_back(8'h13); exp_err.push_back(1'b0);
    send_cmd(2'b01, 24'h0, 12'h0, acc);
    wait_done(1000, dc);
    check("post_rst_rdid_hdr", last_hdr, 32'h90000000);

    repeat (5) @(negedge clk);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("done_queue_empty", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: sck half-period in clk cycles, legal range >=1.
REQ-002 Parameter LEN_W, default 12: width of read byte count.
REQ-003 Parameter CS_GAP, default 4: minimum cs-high clk cycles between transactions.
REQ-004 Parameter RES_WAIT, default 64: clk cycles held after RESUME before done.
REQ-005 Port clk  in  1: single clock, all logic rising-edge.
REQ-006 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 Ports cmd_valid in 1 / cmd_ready out 1: command handshake, accepted when both high on a clk edge.
REQ-008 Port cmd_op  in  2: 00 RESUME(0xAB), 01 READ_ID(0x90), 10 READ(0x03), 11 FAST_READ(0x0B).
REQ-009 Ports cmd_addr in 24 and cmd_len in LEN_W: start address and byte count, used by READ and FAST_READ.
REQ-010 Ports rd_data out 8 / rd_valid out 1 / rd_ready in 1: received-byte stream, transferred when both high.
REQ-011 Ports busy out 1, done out 1 (one-cycle pulse at end of command), err out 1 (valid with done).
REQ-012 Ports cs out 1 (active-low), sck out 1, mosi out 1, miso in 1: SPI flash pins.

Function
REQ-013 SPI mode 0 SHALL apply: sck idles low; mosi changes after falling edges; miso sampled on rising edges; MSB first; one bit = 2*CLK_DIV clk cycles.
REQ-014 FSM states SHALL be IDLE, OPCODE, ADDR, DUMMY, DATA, HOLD, GAP, WAIT.
REQ-015 IDLE: cmd_ready=1, busy=0; an accepted command latches op/addr/len and moves to OPCODE; cs falls on the next cycle.
REQ-016 OPCODE shifts 8 bits; RESUME then goes to GAP, others to ADDR.
REQ-017 ADDR shifts 24 bits (cmd_addr for READ/FAST_READ, 24'h000000 for READ_ID); then DUMMY for FAST_READ, else DATA.
REQ-018 DUMMY shifts 8 clocks with mosi=0, then DATA.
REQ-019 DATA receives bytes; byte count is cmd_len for READ/FAST_READ and exactly 2 for READ_ID (manufacturer, device).
REQ-020 Each completed byte SHALL load rd_data and set rd_valid; rd_valid holds until rd_ready.
REQ-021 Backpressure: if a further byte is due while rd_valid is still high, the FSM enters HOLD with sck low, no edges, and cs low; it resumes on the cycle after the transfer; no byte is lost or duplicated.
REQ-022 After the last byte's transfer, cs rises, GAP holds cs high CS_GAP cycles, then done pulses and the FSM returns to IDLE.
REQ-023 RESUME: after GAP, WAIT counts RES_WAIT cycles before done.
REQ-024 READ/FAST_READ with cmd_len=0: no cs assertion; done with err=0 one cycle after acceptance.
REQ-025 Illegal op (FAST_READ when compiled out): no SPI activity; done with err=1 one cycle after acceptance.
REQ-026 cmd_ready=0 whenever busy=1; commands are not queued.
REQ-027 Address SHALL be sent as-is; flash-side wrap at the top of memory is not handled by this block.

Reset
REQ-028 rst_n low SHALL immediately force cs=1, sck=0, mosi=0, rd_valid=0, done=0, err=0, busy=0, cmd_ready=0, FSM=IDLE, all counters 0, including mid-transaction.
REQ-029 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-030 Macro SPI_FLASH_FAST_READ_EN defined: op 11 performs FAST_READ with 8 dummy clocks; undefined: op 11 is illegal per REQ-025 and the DUMMY state is not built.

Structure
REQ-031 A shared package SHALL hold opcode constants (0xAB, 0x90, 0x03, 0x0B), the cmd_op encoding and the FSM state enumeration.
REQ-032 Sub-module spi_shift_engine SHALL own sck generation from CLK_DIV and 8-bit MSB-first shift/sample, with start/byte_done handshake; the FSM sequences it.

Verification
REQ-033 RESUME at CLK_DIV=2 -> mosi 0xAB, cs low for exactly 32 clk cycles, done CS_GAP+RES_WAIT cycles after cs rises.
REQ-034 READ_ID with flash model returning EF,13 -> mosi 90 00 00 00, rd_data EF then 13, done, err=0.
REQ-035 READ addr 0x012345 len 4 with rd_ready tied 0 for 100 cycles after first byte -> sck frozen in HOLD, then 4 bytes in order, no loss.
REQ-036 READ len 0 -> cs never falls, done one cycle after acceptance, err=0; op 11 without macro -> err=1.
REQ-037 rst_n asserted mid-DATA -> cs=1, sck=0, rd_valid=0 asynchronously; following READ_ID completes correctly.
REQ-038 With SPI_FLASH_FAST_READ_EN, FAST_READ len 2 -> mosi 0B, address, 8 dummy clocks, then 2 bytes.
